fifo_mode_responder: RTL and testbench

- Synthesizable, cycle-accurate responder for the memory-core FIFO-mode port protocol.
- Accepts pushes on data_in/wen_in and pops on ren_in; returns popped words on data_out/valid_out with one-cycle latency.
- Publishes full/empty/almost status.
- Serves as the golden FIFO end of the accelerator-QED harness and as a drop-in stand-in for the memory core when the tester is verified in isolation.

---
 rtl/fifo_mode_responder.sv | 115 +++++++++++
 tb/tb_fifo_mode_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mode_responder.sv
// fifo_mode_responder
// Cycle-accurate responder for the memory-core FIFO-mode port. Pushed words
// are stored in a circular buffer whose effective capacity is set by `depth`;
// popped words come back on data_out/valid_out one cycle after the pop.
//
// Ports:
//   clk           single clock, posedge
//   reset         synchronous active-high clear (honoured even with clk_en=0)
//   clk_en        1 = run, 0 = freeze all state
//   flush         synchronous clear of contents, same effect as reset
//   depth         configured capacity (0 or > 2^ADDR_WIDTH selects 2^ADDR_WIDTH)
//   almost_count  threshold for almost_full / almost_empty
//   data_in       push data
//   wen_in        push request
//   ren_in        pop request
//   data_out      popped word
//   valid_out     data_out carries a popped word this cycle
//   full, empty, almost_full, almost_empty   status from the registered count
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
module fifo_mode_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [15:0]           depth,
  input  logic [3:0]            almost_count,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen_in,
  input  logic                  ren_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int          PTR_W   = ADDR_WIDTH + 1;
  localparam int unsigned CAP_MAX = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [CAP_MAX];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] cap;
  logic             push_ok;
  logic             pop_ok;
  logic             clear;
  logic [16:0]      af_sum;

  // Pointers wrap at the configured capacity, not at the physical size.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W-1:0] c);
    return (p == c - PTR_W'(1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    cap = PTR_W'(CAP_MAX);
    if (depth != 16'd0 && 32'(depth) <= CAP_MAX)
      cap = depth[PTR_W-1:0];
  end

  assign clear   = reset || flush;
  assign full    = (count == cap);
  assign empty   = (count == '0);
  assign push_ok = wen_in && !full;
  assign pop_ok  = ren_in && !empty;

  // 17-bit sum so that a threshold larger than cap can never wrap.
  assign af_sum       = {{(17-PTR_W){1'b0}}, count} + {13'd0, almost_count};
  assign almost_full  = (af_sum >= {{(17-PTR_W){1'b0}}, cap});
  assign almost_empty = (count <= {{(PTR_W-4){1'b0}}, almost_count});

  // Storage is never cleared; only the pointers are.
  always_ff @(posedge clk) begin
    if (!clear && clk_en && push_ok)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clk_en) begin
      if (push_ok)
        wr_ptr <= ptr_next(wr_ptr, cap);
      if (pop_ok) begin
        rd_ptr   <= ptr_next(rd_ptr, cap);
        data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
      valid_out <= pop_ok;
      if (push_ok && !pop_ok)
        count <= count + PTR_W'(1);
      else if (pop_ok && !push_ok)
        count <= count - PTR_W'(1);
      if (wen_in && full)
        overflow <= 1'b1;
      if (ren_in && empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_mode_responder.sv
module tb_fifo_mode_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        flush;
  logic [15:0] depth;
  logic [3:0]  almost_count;
  logic [15:0] data_in;
  logic        wen_in;
  logic        ren_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;

  int tests = 0;
  int fails = 0;

  fifo_mode_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
    .depth(depth), .almost_count(almost_count), .data_in(data_in),
    .wen_in(wen_in), .ren_in(ren_in), .data_out(data_out),
    .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; depth = 16'd4;
    almost_count = 4'd1; data_in = '0; wen_in = 1'b0; ren_in = 1'b0;
    tick(); tick();
    reset = 1'b0;

    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk1("rst_aempty", almost_empty, 1'b1);
    chk1("rst_afull", almost_full, 1'b0);
    chk1("rst_valid", valid_out, 1'b0);
    chk16("rst_data", data_out, 16'h0000);
    chk1("rst_ovf", overflow, 1'b0);
    chk1("rst_udf", underflow, 1'b0);

    // depth 4, almost_count 1: fill and overflow
    wen_in = 1'b1; data_in = 16'hA1; tick();
    chk1("p1_empty", empty, 1'b0);
    chk1("p1_aempty", almost_empty, 1'b1);
    chk1("p1_afull", almost_full, 1'b0);
    data_in = 16'hA2; tick();
    chk1("p2_aempty", almost_empty, 1'b0);
    chk1("p2_afull", almost_full, 1'b0);
    data_in = 16'hA3; tick();
    chk1("p3_afull", almost_full, 1'b1);
    chk1("p3_full", full, 1'b0);
    data_in = 16'hA4; tick();
    chk1("p4_full", full, 1'b1);
    chk1("p4_ovf", overflow, 1'b0);
    data_in = 16'hA5; tick();
    chk1("p5_ovf", overflow, 1'b1);
    chk1("p5_full", full, 1'b1);
    wen_in = 1'b0;

    // drain back-to-back, then underflow
    ren_in = 1'b1; tick();
    chk1("r1_valid", valid_out, 1'b1);
    chk16("r1_data", data_out, 16'hA1);
    chk1("r1_full", full, 1'b0);
    tick();
    chk1("r2_valid", valid_out, 1'b1);
    chk16("r2_data", data_out, 16'hA2);
    tick();
    chk1("r3_valid", valid_out, 1'b1);
    chk16("r3_data", data_out, 16'hA3);
    tick();
    chk1("r4_valid", valid_out, 1'b1);
    chk16("r4_data", data_out, 16'hA4);
    chk1("r4_empty", empty, 1'b1);
    chk1("r4_udf", underflow, 1'b0);
    tick();
    chk1("r5_valid", valid_out, 1'b0);
    chk1("r5_udf", underflow, 1'b1);
    chk16("r5_data_hold", data_out, 16'hA4);
    chk1("r5_ovf_sticky", overflow, 1'b1);
    ren_in = 1'b0;

    flush = 1'b1; tick(); flush = 1'b0;
    chk1("fl_ovf", overflow, 1'b0);
    chk1("fl_udf", underflow, 1'b0);
    chk16("fl_data", data_out, 16'h0000);

    // depth 3: streaming with simultaneous push/pop
    depth = 16'd3;
    wen_in = 1'b1; data_in = 16'h0; tick();
    ren_in = 1'b1;
    for (int i = 1; i < 10; i++) begin
      data_in = 16'(i);
      tick();
      chk1("st_valid", valid_out, 1'b1);
      chk16("st_data", data_out, 16'(i - 1));
      chk1("st_count1", almost_empty && !empty, 1'b1);
    end
    wen_in = 1'b0; tick();
    chk1("st_last_valid", valid_out, 1'b1);
    chk16("st_last_data", data_out, 16'h9);
    chk1("st_empty", empty, 1'b1);
    ren_in = 1'b0; tick();
    chk1("st_idle_valid", valid_out, 1'b0);

    // depth 0 selects 512 entries
    flush = 1'b1; tick(); flush = 1'b0;
    depth = 16'd0; almost_count = 4'd4;
    wen_in = 1'b1;
    for (int i = 0; i < 511; i++) begin
      data_in = 16'(i + 16'h100);
      tick();
    end
    chk1("d0_511_full", full, 1'b0);
    chk1("d0_511_afull", almost_full, 1'b1);
    data_in = 16'hBEEF; tick();
    chk1("d0_512_full", full, 1'b1);
    wen_in = 1'b0; ren_in = 1'b1; tick();
    chk16("d0_pop_data", data_out, 16'h0100);
    chk1("d0_pop_full", full, 1'b0);
    ren_in = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    depth = 16'd4; almost_count = 4'd1;

    // simultaneous push/pop on empty: no bypass
    wen_in = 1'b1; ren_in = 1'b1; data_in = 16'h55; tick();
    chk1("eb_valid", valid_out, 1'b0);
    chk1("eb_udf", underflow, 1'b1);
    chk1("eb_empty", empty, 1'b0);
    chk1("eb_aempty", almost_empty, 1'b1);
    wen_in = 1'b0; tick();
    chk1("eb_pop_valid", valid_out, 1'b1);
    chk16("eb_pop_data", data_out, 16'h55);
    chk1("eb_pop_empty", empty, 1'b1);
    ren_in = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;

    // clk_en freeze
    wen_in = 1'b1; data_in = 16'h11; tick();
    data_in = 16'h22; tick();
    wen_in = 1'b0;
    clk_en = 1'b0; wen_in = 1'b1; ren_in = 1'b1; data_in = 16'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("ce_empty", empty, 1'b0);
      chk1("ce_aempty", almost_empty, 1'b0);
      chk1("ce_full", full, 1'b0);
      chk1("ce_valid", valid_out, 1'b0);
      chk1("ce_ovf", overflow, 1'b0);
      chk1("ce_udf", underflow, 1'b0);
    end
    clk_en = 1'b1; wen_in = 1'b0; tick();
    chk1("ce_r1_valid", valid_out, 1'b1);
    chk16("ce_r1_data", data_out, 16'h11);
    tick();
    chk1("ce_r2_valid", valid_out, 1'b1);
    chk16("ce_r2_data", data_out, 16'h22);
    chk1("ce_r2_empty", empty, 1'b1);
    ren_in = 1'b0; tick();

    // flush mid-stream with concurrent pop
    wen_in = 1'b1;
    data_in = 16'h31; tick();
    data_in = 16'h32; tick();
    data_in = 16'h33; tick();
    wen_in = 1'b0;
    chk1("mf_pre_aempty", almost_empty, 1'b0);
    ren_in = 1'b1; flush = 1'b1; tick();
    flush = 1'b0; ren_in = 1'b0;
    chk1("mf_valid", valid_out, 1'b0);
    chk1("mf_empty", empty, 1'b1);
    chk1("mf_ovf", overflow, 1'b0);
    chk1("mf_udf", underflow, 1'b0);
    wen_in = 1'b1; data_in = 16'h77; tick();
    wen_in = 1'b0; ren_in = 1'b1; tick();
    chk1("mf_pop_valid", valid_out, 1'b1);
    chk16("mf_pop_data", data_out, 16'h77);
    ren_in = 1'b0;

    // reset wins over clk_en=0
    wen_in = 1'b1; data_in = 16'h44; tick();
    wen_in = 1'b0;
    chk1("rc_pre_empty", empty, 1'b0);
    clk_en = 1'b0; reset = 1'b1; tick();
    reset = 1'b0; clk_en = 1'b1;
    chk1("rc_empty", empty, 1'b1);
    chk1("rc_valid", valid_out, 1'b0);
    chk16("rc_data", data_out, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
